debug_trace_monitor: RTL and testbench
======================================

Name: debug_trace_monitor

Overview:
- Hardware run-monitor that sits directly downstream of riscv_soc_top's debug port.
- Samples debug_pc, debug_instr and debug_stall every clock and counts cycles and retired (non-NOP, non-stalled) instructions.
- Detects program termination: a tight loop of period 1-4 or a cycle timeout.
- Freezes results and raises done for host/JTAG readout.
- Provides silicon-side equivalents of the simulation-only end-of-program detection and CPI metrics.

Parameters:
- CNT_W, 32: width of cycle_count and instr_count.
- HIST_DEPTH, 16: PC history depth; power of 2, at least 8.
- TIMEOUT_CYCLES, 20000: sampled cycles before forced done; 0 disables the timeout.
- NOP_INSTR, 32'h00000013: encoding treated as a non-retired bubble.

Ports:
- clk, input, 1: system clock.
- rst_n, input, 1: asynchronous active-low reset.
- enable, input, 1: sample qualifier; 0 pauses monitoring.
- clear, input, 1: synchronous restart to IDLE.
- debug_pc, input, 32: PC from SoC debug port.
- debug_instr, input, 32: instruction from SoC debug port.
- debug_stall, input, 1: pipeline stall from SoC debug port.
- done, output, 1: level; high in DONE state.
- done_pulse, output, 1: one-cycle pulse on entry to DONE.
- done_reason, output, 3: 0 none, 1-4 loop period, 7 timeout.
- loop_pc, output, 32: debug_pc of the terminating sample.
- cycle_count, output, CNT_W: sampled cycles in RUN.
- instr_count, output, CNT_W: retired instructions.

Behaviour:
- Clock and reset: single clock domain clk. rst_n is asynchronous assert, synchronous-deassert usage assumed upstream.
- Reset values: all outputs 0; state IDLE; history invalid; all match counters 0.
- FSM transitions:
  - IDLE -> RUN on the first cycle with enable=1. That cycle is already sampled as sample #1.
  - RUN -> DONE when a detector fires.
  - DONE holds until clear or reset.
  - clear=1 from any state -> IDLE next cycle: counters, history, match counts, done_reason and loop_pc zeroed. clear has priority over everything.
- Sampling:
  - A sample is any RUN or IDLE->RUN cycle with enable=1.
  - enable=0 in RUN: no counter, history or match update (pure pause).
- Counters:
  - cycle_count +1 per sample.
  - instr_count +1 per sample with debug_instr != NOP_INSTR and debug_stall=0.
  - Both saturate at all-ones.
  - The terminating sample is included in both counters.
- Loop detectors (compare the current sample against stored history, before the history write):
  - Period 1: debug_pc == prev_pc and debug_instr == prev_instr. Fires on the 3rd consecutive match.
  - Period p in {2,3,4}: debug_pc == pc from p samples earlier. Valid only once at least p samples are stored. Fires on the (2*p)th consecutive match.
  - Any non-match resets that detector's counter to 0. Match counters saturate.
- Timeout: fires when the sample makes cycle_count equal TIMEOUT_CYCLES.
- Simultaneous fire: the smallest loop period wins; any loop wins over timeout.
- On fire, registered at the same edge:
  - done=1, done_pulse=1 for one cycle.
  - done_reason set.
  - loop_pc = the sample's debug_pc.
  - Counters updated, then frozen.
- DONE ignores enable and all inputs except clear.
- Latency: done is visible the cycle after the terminating sample edge.
- History buffer:
  - Circular, write pointer wraps modulo HIST_DEPTH.
  - Lookback index = (wr_ptr - p) mod HIST_DEPTH.
  - Fill count saturates at HIST_DEPTH.
- Reset mid-RUN: immediate return to reset values; no done_pulse.

Decomposition:
- Package soc_debug_pkg holds:
  - NOP_INSTR constant.
  - done_reason codes: REASON_NONE=0, REASON_LOOP1..4=1..4, REASON_TIMEOUT=7.
  - FSM state enum: IDLE, RUN, DONE.
- Sub-module pc_history_buf: circular PC buffer with write enable, clear, fill count, and four combinational lookback taps (1..4). Also stores prev_instr for the period-1 detector.
- Top level: FSM, counters, four detectors, priority encoder.

Test Plan:
1. Reset: rst_n=0 while toggling inputs -> all outputs 0. After release with enable=0 for 5 cycles, cycle_count stays 0.
2. Period-1 loop: enable=1; PCs 0x00..0x3C step 4 (16 samples, distinct instrs), then PC 0x40 with instr 0x0000006F held -> done on the 20th sample.
   - done_reason=1, loop_pc=0x40, cycle_count=20, instr_count=20.
   - done_pulse high exactly 1 cycle.
3. Period-2 loop: samples alternate 0x100/0x104 with different instrs -> done on the 6th sample, done_reason=2, cycle_count=6.
4. Retire counting: 10 samples of incrementing PC with stall=1 on samples 2,5,7 and instr=NOP on samples 3,9 -> cycle_count=10, instr_count=5, done=0.
5. Timeout and pause: TIMEOUT_CYCLES=50, incrementing PC, enable=0 for 7 cycles mid-run -> done after the 50th sample (57 RUN clocks), done_reason=7, cycle_count=50.
6. Clear and reset: clear=1 in DONE -> next cycle all outputs 0, then a new period-1 run reproduces scenario 2 results. rst_n pulse mid-RUN -> outputs 0 asynchronously, no done_pulse.

Source files
------------

// File: rtl/soc_debug_pkg.sv
// Shared constants, reason codes and FSM encoding for the debug trace monitor.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package soc_debug_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [2:0] REASON_NONE    = 3'd0;
    localparam logic [2:0] REASON_LOOP1   = 3'd1;
    localparam logic [2:0] REASON_LOOP2   = 3'd2;
    localparam logic [2:0] REASON_LOOP3   = 3'd3;
    localparam logic [2:0] REASON_LOOP4   = 3'd4;
    localparam logic [2:0] REASON_TIMEOUT = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Consecutive matches needed before a period-p loop is declared.
    function automatic logic [3:0] loop_fire_count(input int unsigned period);
        return (period == 1) ? 4'd3 : 4'(2 * period);
    endfunction

endpackage

// File: rtl/pc_history_buf.sv
// Circular PC history with four lookback taps plus the previous instruction word.
// Latency: writes land at the clock edge; taps are combinational from the stored state.
// Backpressure: none; wr_en is a pure qualifier, clr has priority over wr_en.
module pc_history_buf #(
    parameter int HIST_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          clr,
    input  logic                          wr_en,
    input  logic [31:0]                   wr_pc,
    input  logic [31:0]                   wr_instr,
    output logic [$clog2(HIST_DEPTH):0]   fill,
    output logic [4:1][31:0]              tap_pc,
    output logic [31:0]                   prev_instr
);

    localparam int PTR_W  = $clog2(HIST_DEPTH);
    localparam int FILL_W = PTR_W + 1;

    logic [31:0]      mem [HIST_DEPTH];
    logic [PTR_W-1:0] wr_ptr;

    // Storage needs no reset: entries are only trusted up to the fill count.
    always_ff @(posedge clk) begin
        if (wr_en && !clr) begin
            mem[wr_ptr] <= wr_pc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            fill       <= '0;
            prev_instr <= '0;
        end else if (clr) begin
            wr_ptr     <= '0;
            fill       <= '0;
            prev_instr <= '0;
        end else if (wr_en) begin
            wr_ptr     <= wr_ptr + PTR_W'(1);
            prev_instr <= wr_instr;
            if (fill != FILL_W'(HIST_DEPTH)) begin
                fill <= fill + FILL_W'(1);
            end
        end
    end

    always_comb begin
        tap_pc = '0;
        for (int p = 1; p <= 4; p++) begin
            tap_pc[p] = mem[wr_ptr - PTR_W'(p)];
        end
    end

endmodule

// File: rtl/debug_trace_monitor.sv
// Run monitor on the SoC debug port: counts cycles/retired instrs, stops on a tight loop or timeout.
// Latency: done/done_pulse/results register on the terminating sample edge (visible next cycle).
// Backpressure: none; enable pauses sampling, clear restarts, DONE holds until clear.
module debug_trace_monitor #(
    parameter int          CNT_W          = 32,
    parameter int          HIST_DEPTH     = 16,
    parameter int          TIMEOUT_CYCLES = 20000,
    parameter logic [31:0] NOP_INSTR      = 32'h0000_0013
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             clear,
    input  logic [31:0]      debug_pc,
    input  logic [31:0]      debug_instr,
    input  logic             debug_stall,
    output logic             done,
    output logic             done_pulse,
    output logic [2:0]       done_reason,
    output logic [31:0]      loop_pc,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] instr_count
);

    import soc_debug_pkg::*;

    localparam int               FILL_W      = $clog2(HIST_DEPTH) + 1;
    localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);

    state_t             state;
    logic               sample;
    logic [FILL_W-1:0]  fill;
    logic [4:1][31:0]   tap_pc;
    logic [31:0]        prev_instr;
    logic [4:1]         tap_vld;
    logic [4:1]         match;
    logic [4:1]         fire;
    logic [3:0]         mcnt [4:1];
    logic [CNT_W-1:0]   cyc_next;
    logic [CNT_W-1:0]   ins_next;
    logic               retire;
    logic               timeout_hit;
    logic [2:0]         fire_reason;

    assign sample = enable && !clear && (state != DONE);
    assign done   = (state == DONE);

    pc_history_buf #(
        .HIST_DEPTH (HIST_DEPTH)
    ) u_hist (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (clear),
        .wr_en      (sample),
        .wr_pc      (debug_pc),
        .wr_instr   (debug_instr),
        .fill       (fill),
        .tap_pc     (tap_pc),
        .prev_instr (prev_instr)
    );

    // Detectors compare against history as it stood before this sample's write.
    always_comb begin
        tap_vld = '0;
        match   = '0;
        fire    = '0;
        for (int p = 1; p <= 4; p++) begin
            tap_vld[p] = (fill >= FILL_W'(p));
            match[p]   = tap_vld[p] && (debug_pc == tap_pc[p]);
        end
        match[1] = match[1] && (debug_instr == prev_instr);
        for (int p = 1; p <= 4; p++) begin
            fire[p] = match[p] && (mcnt[p] >= (loop_fire_count(p) - 4'd1));
        end
    end

    always_comb begin
        retire      = (debug_instr != NOP_INSTR) && !debug_stall;
        cyc_next    = (cycle_count == '1) ? cycle_count : cycle_count + CNT_W'(1);
        ins_next    = (retire && (instr_count != '1)) ? instr_count + CNT_W'(1) : instr_count;
        timeout_hit = (TIMEOUT_CYCLES != 0) && (cyc_next == TIMEOUT_VAL);
        fire_reason = REASON_NONE;
        if (fire[1])          fire_reason = REASON_LOOP1;
        else if (fire[2])     fire_reason = REASON_LOOP2;
        else if (fire[3])     fire_reason = REASON_LOOP3;
        else if (fire[4])     fire_reason = REASON_LOOP4;
        else if (timeout_hit) fire_reason = REASON_TIMEOUT;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            done_pulse  <= 1'b0;
            done_reason <= REASON_NONE;
            loop_pc     <= '0;
            cycle_count <= '0;
            instr_count <= '0;
            for (int p = 1; p <= 4; p++) mcnt[p] <= '0;
        end else if (clear) begin
            state       <= IDLE;
            done_pulse  <= 1'b0;
            done_reason <= REASON_NONE;
            loop_pc     <= '0;
            cycle_count <= '0;
            instr_count <= '0;
            for (int p = 1; p <= 4; p++) mcnt[p] <= '0;
        end else begin
            done_pulse <= 1'b0;
            if (sample) begin
                state       <= RUN;
                cycle_count <= cyc_next;
                instr_count <= ins_next;
                for (int p = 1; p <= 4; p++) begin
                    if (!match[p])            mcnt[p] <= '0;
                    else if (mcnt[p] != 4'hF) mcnt[p] <= mcnt[p] + 4'd1;
                end
                if (fire_reason != REASON_NONE) begin
                    state       <= DONE;
                    done_pulse  <= 1'b1;
                    done_reason <= fire_reason;
                    loop_pc     <= debug_pc;
                end
            end
        end
    end

endmodule

// File: tb/tb_debug_trace_monitor.sv
// Directed bench for debug_trace_monitor: per-cycle vector table plus hand sequences.
// Timeout shortened to 50 samples so the timeout path is reachable quickly.
module tb_debug_trace_monitor;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        clear;
    logic [31:0] debug_pc;
    logic [31:0] debug_instr;
    logic        debug_stall;
    logic        done;
    logic        done_pulse;
    logic [2:0]  done_reason;
    logic [31:0] loop_pc;
    logic [31:0] cycle_count;
    logic [31:0] instr_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    debug_trace_monitor #(
        .CNT_W          (32),
        .HIST_DEPTH     (16),
        .TIMEOUT_CYCLES (50),
        .NOP_INSTR      (32'h0000_0013)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .clear       (clear),
        .debug_pc    (debug_pc),
        .debug_instr (debug_instr),
        .debug_stall (debug_stall),
        .done        (done),
        .done_pulse  (done_pulse),
        .done_reason (done_reason),
        .loop_pc     (loop_pc),
        .cycle_count (cycle_count),
        .instr_count (instr_count)
    );

    typedef struct {
        logic        en;
        logic        clr;
        logic        stall;
        logic [31:0] pc;
        logic [31:0] instr;
        logic        e_done;
        logic        e_pulse;
        logic [2:0]  e_reason;
        logic [31:0] e_loop_pc;
        logic [31:0] e_cyc;
        logic [31:0] e_ins;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic en, input logic clr, input logic stall,
                       input logic [31:0] pc, input logic [31:0] instr,
                       input logic e_done, input logic e_pulse, input logic [2:0] e_reason,
                       input logic [31:0] e_loop_pc, input logic [31:0] e_cyc,
                       input logic [31:0] e_ins);
        vec_t v;
        v.en = en; v.clr = clr; v.stall = stall; v.pc = pc; v.instr = instr;
        v.e_done = e_done; v.e_pulse = e_pulse; v.e_reason = e_reason;
        v.e_loop_pc = e_loop_pc; v.e_cyc = e_cyc; v.e_ins = e_ins;
        vecs.push_back(v);
    endtask

    // Drive one cycle of inputs, let the edge happen, sample 1ns later.
    task automatic step(input logic en, input logic clr, input logic stall,
                        input logic [31:0] pc, input logic [31:0] instr);
        enable = en; clear = clr; debug_stall = stall; debug_pc = pc; debug_instr = instr;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic e_done, input logic e_pulse,
                           input logic [2:0] e_reason, input logic [31:0] e_loop_pc,
                           input logic [31:0] e_cyc, input logic [31:0] e_ins);
        chk({tag, ".done"},        32'(done),        32'(e_done));
        chk({tag, ".done_pulse"},  32'(done_pulse),  32'(e_pulse));
        chk({tag, ".done_reason"}, 32'(done_reason), 32'(e_reason));
        chk({tag, ".loop_pc"},     loop_pc,          e_loop_pc);
        chk({tag, ".cycle_count"}, cycle_count,      e_cyc);
        chk({tag, ".instr_count"}, instr_count,      e_ins);
    endtask

    task automatic run_vecs(input int first, input int last, input string tag);
        for (int i = first; i <= last; i++) begin
            step(vecs[i].en, vecs[i].clr, vecs[i].stall, vecs[i].pc, vecs[i].instr);
            chk_all($sformatf("%s[%0d]", tag, i), vecs[i].e_done, vecs[i].e_pulse,
                    vecs[i].e_reason, vecs[i].e_loop_pc, vecs[i].e_cyc, vecs[i].e_ins);
        end
    endtask

    int s2_last;
    int s3_last;
    int s4_last;
    int run_clks;
    logic [31:0] ins_exp [1:10];

    initial begin
        // Period-1 loop: 16 distinct PCs, then 0x40/0x6F held; fires on sample 20.
        for (int i = 0; i < 16; i++)
            add(1, 0, 0, 32'(4 * i), 32'h1000_0000 + 32'(i), 0, 0, 0, 0, 32'(i + 1), 32'(i + 1));
        for (int i = 16; i < 19; i++)
            add(1, 0, 0, 32'h40, 32'h6F, 0, 0, 0, 0, 32'(i + 1), 32'(i + 1));
        add(1, 0, 0, 32'h40, 32'h6F, 1, 1, 3'd1, 32'h40, 20, 20);
        add(1, 0, 0, 32'h44, 32'h99, 1, 0, 3'd1, 32'h40, 20, 20);
        add(1, 1, 0, 32'h44, 32'h99, 0, 0, 0, 0, 0, 0);
        s2_last = vecs.size() - 1;

        // Period-2 loop: alternating 0x100/0x104; fires on sample 6.
        for (int k = 1; k <= 5; k++)
            add(1, 0, 0, (k % 2 == 1) ? 32'h100 : 32'h104, 32'h2000_0000 + 32'(k % 2),
                0, 0, 0, 0, 32'(k), 32'(k));
        add(1, 0, 0, 32'h104, 32'h2000_0000, 1, 1, 3'd2, 32'h104, 6, 6);
        add(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        s3_last = vecs.size() - 1;

        // Retire counting: stalls on 2,5,7, NOPs on 3,9.
        ins_exp = '{1, 1, 1, 2, 2, 3, 3, 4, 4, 5};
        for (int k = 1; k <= 10; k++)
            add(1, 0, (k == 2 || k == 5 || k == 7),
                32'h200 + 32'(4 * k), (k == 3 || k == 9) ? 32'h13 : 32'h3000_0000 + 32'(k),
                0, 0, 0, 0, 32'(k), ins_exp[k]);
        add(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        s4_last = vecs.size() - 1;

        // Reset with inputs toggling: outputs must stay at zero.
        rst_n = 1'b0;
        enable = 0; clear = 0; debug_pc = 0; debug_instr = 0; debug_stall = 0;
        for (int i = 0; i < 4; i++) begin
            step(i[0], 0, ~i[0], 32'h40, 32'h6F);
            chk_all($sformatf("reset[%0d]", i), 0, 0, 0, 0, 0, 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 0, 32'h500 + 32'(i), 32'h1234);
            chk($sformatf("idle_cyc[%0d]", i), cycle_count, 0);
        end
        chk("idle.done", 32'(done), 0);

        run_vecs(0, s2_last, "loop1");
        run_vecs(s2_last + 1, s3_last, "loop2");
        run_vecs(s3_last + 1, s4_last, "retire");

        // Timeout with a 7-cycle pause after sample 25.
        run_clks = 0;
        for (int k = 1; k <= 50; k++) begin
            step(1, 0, 0, 32'h1000 + 32'(4 * k), 32'h4000_0000 + 32'(k));
            run_clks++;
            if (k == 25) begin
                for (int j = 0; j < 7; j++) begin
                    step(0, 0, 0, 32'h1000, 32'h4000_0000);
                    run_clks++;
                    chk($sformatf("pause_cyc[%0d]", j), cycle_count, 25);
                    chk($sformatf("pause_done[%0d]", j), 32'(done), 0);
                end
            end
            if (k == 49) chk("tmo.pre_done", 32'(done), 0);
        end
        chk_all("tmo", 1, 1, 3'd7, 32'h1000 + 32'(200), 50, 50);
        chk("tmo.clocks", 32'(run_clks), 57);
        step(1, 0, 0, 32'h0, 32'h0);
        chk_all("tmo.hold", 1, 0, 3'd7, 32'h1000 + 32'(200), 50, 50);
        step(0, 1, 0, 0, 0);
        chk_all("tmo.clear", 0, 0, 0, 0, 0, 0);

        // Fresh period-1 run after clear must reproduce the first result.
        run_vecs(0, s2_last, "rerun");

        // Asynchronous reset mid-run: immediate zero, no done_pulse.
        for (int k = 1; k <= 3; k++) step(1, 0, 0, 32'h800 + 32'(4 * k), 32'h5000_0000);
        chk("midrst.pre_cyc", cycle_count, 3);
        rst_n = 1'b0;
        #1;
        chk_all("midrst.async", 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            step(1, 0, 0, 32'h800, 32'h5000_0000);
            chk($sformatf("midrst.pulse[%0d]", i), 32'(done_pulse), 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step(0, 0, 0, 0, 0);
        chk_all("postrst", 0, 0, 0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
